// File: rtl/rr_priority_arbiter.sv
// -----------------------------------------------------------------------------
// rr_priority_arbiter
//
// Registered N-way arbiter. Issues one grant at a time, held until the owner
// releases it (done pulse or dropping its request). Two winner-selection modes:
//   mode=0  fixed priority, highest request index wins
//   mode=1  round-robin, search upward from a rotating pointer with wrap
// All outputs come straight from flops; there is always one idle bubble cycle
// between consecutive grants.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (wins over every other input)
//   req        [N-1:0] request lines, req[i]=1 -> requester i wants the resource
//   mode       0 = fixed priority, 1 = round-robin (sampled only when granting)
//   done       1-cycle release strobe from the current owner (ignored in IDLE)
//   grant      [N-1:0] one-hot grant, registered
//   grant_idx  [W-1:0] binary index of the owner, 0 when no grant
//   V          1 while a grant is active (equals |grant)
// -----------------------------------------------------------------------------
module rr_priority_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         done,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         V
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state;
  logic [W-1:0]   ptr;       // round-robin search start
  logic           mode_q;    // mode captured when the current grant was issued

  logic [W-1:0]   fix_idx;
  logic [W-1:0]   rr_idx;
  logic [W-1:0]   win_idx;
  logic           release_now;

  // (a + b) mod N for a < N and b < N; N need not be a power of two.
  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] a,
                                            input int unsigned b);
    int unsigned s;
    s = {{(32-W){1'b0}}, a} + b;
    if (s >= 32'(N)) s = s - 32'(N);
    return s[W-1:0];
  endfunction

  // Winner selection. Both searches let a later loop iteration overwrite an
  // earlier one, so the iteration order encodes the priority.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    fix_idx     = '0;
    rr_idx      = '0;
    win_idx     = '0;
    release_now = 1'b0;

    // Ascending scan: the highest set index is the last one written.
    for (int i = 0; i < N; i++) begin
      if (req[i]) fix_idx = W'(i);
    end

    // Descending offset scan from ptr: the smallest offset (first request
    // found going upward from ptr, wrapping) is the last one written.
    for (int off = N - 1; off >= 0; off--) begin
      if (req[wrap_add(ptr, off)]) rr_idx = wrap_add(ptr, off);
    end

    win_idx     = mode ? rr_idx : fix_idx;
    release_now = done | ~req[grant_idx];
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      V         <= 1'b0;
      ptr       <= '0;
      mode_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant     <= N'(1) << win_idx;
            grant_idx <= win_idx;
            V         <= 1'b1;
            mode_q    <= mode;
            state     <= BUSY;
          end
        end

        BUSY: begin
          // Other requests are never allowed to pre-empt the owner; only the
          // owner's done or the loss of its own request ends the grant.
          if (release_now) begin
            grant     <= '0;
            grant_idx <= '0;
            V         <= 1'b0;
            state     <= IDLE;
            if (mode_q) ptr <= wrap_add(grant_idx, 1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_priority_arbiter
//
// Directed bench for rr_priority_arbiter with N=4. Each cycle the bench drives
// inputs, advances its own behavioural model of the arbiter and pushes the
// expected registered outputs onto a scoreboard queue; after the clock edge the
// entry is popped and compared with the DUT. Key spec scenarios also carry
// hand-written constant expectations.
// -----------------------------------------------------------------------------
module tb_rr_priority_arbiter;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         mode;
  logic         done;
  logic [N-1:0] grant;
  logic [W-1:0] grant_idx;
  logic         V;

  rr_priority_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mode      (mode),
    .done      (done),
    .grant     (grant),
    .grant_idx (grant_idx),
    .V         (V)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] g;
    logic [W-1:0] idx;
    logic         v;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit m_busy = 1'b0;
  int m_k    = 0;
  int m_ptr  = 0;
  bit m_mode = 1'b0;

  // Expected fixed-priority winner for each 4-bit request pattern.
  int enc_tbl [16] = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3};
  int rr_seq  [5]  = '{0, 1, 2, 3, 0};

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int pick_fixed(input logic [3:0] r);
    casez (r)
      4'b1???: return 3;
      4'b01??: return 2;
      4'b001?: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int pick_rr(input logic [3:0] r, input int p);
    int j;
    for (int s = 0; s < 4; s++) begin
      j = (p + s) % 4;
      if (r[j[1:0]]) return j;
    end
    return 0;
  endfunction

  // One clock cycle: drive, predict, push; then after the edge pop and compare.
  task automatic cyc(input bit r, input logic [3:0] rq, input bit md,
                     input bit dn);
    exp_t e;
    rst  = r;
    req  = rq;
    mode = md;
    done = dn;

    if (r) begin
      m_busy = 1'b0;
      m_ptr  = 0;
    end else if (!m_busy) begin
      if (rq != 4'b0000) begin
        m_k    = md ? pick_rr(rq, m_ptr) : pick_fixed(rq);
        m_mode = md;
        m_busy = 1'b1;
      end
    end else if (dn || !rq[m_k[1:0]]) begin
      m_busy = 1'b0;
      if (m_mode) m_ptr = (m_k + 1) % 4;
    end

    e.g   = m_busy ? 4'(1 << m_k) : 4'b0000;
    e.idx = m_busy ? 2'(m_k) : 2'b00;
    e.v   = m_busy;
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_grant",     32'(grant),     32'(e.g));
    check("sb_grant_idx", 32'(grant_idx), 32'(e.idx));
    check("sb_v",         32'(V),         32'(e.v));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    req  = '0;
    mode = 1'b0;
    done = 1'b0;
    #1;

    // 1. Reset held with all requests asserted, then first fixed grant.
    cyc(1, 4'b1111, 0, 0);
    check("t1_rst_grant", 32'(grant), 32'h0);
    cyc(1, 4'b1111, 0, 0);
    check("t1_rst_v", 32'(V), 32'h0);
    cyc(0, 4'b1111, 0, 0);
    check("t1_first_grant", 32'(grant), 32'h8);
    cyc(0, 4'b1111, 0, 1);

    // 2. Fixed-priority sweep over every request pattern.
    for (int r = 0; r < 16; r++) begin
      cyc(0, 4'(r), 0, 0);
      check("t2_enc_idx", 32'(grant_idx), 32'(enc_tbl[r]));
      check("t2_enc_v",   32'(V),         32'(r != 0));
      cyc(0, 4'(r), 0, 1);
    end

    // 3. Round-robin rotation with all requesters active; bubble after each.
    for (int g = 0; g < 5; g++) begin
      cyc(0, 4'b1111, 1, 0);
      check("t3_rr_idx", 32'(grant_idx), 32'(rr_seq[g]));
      cyc(0, 4'b1111, 1, 1);
      check("t3_bubble", 32'(V), 32'h0);
    end
    // ptr is now 1: grant 1 and release to move ptr to 2.
    cyc(0, 4'b0010, 1, 0);
    cyc(0, 4'b0010, 1, 1);

    // 4. ptr=2, req=0011 -> search wraps to 0, then 1.
    cyc(0, 4'b0011, 1, 0);
    check("t4_wrap_idx", 32'(grant_idx), 32'h0);
    cyc(0, 4'b0011, 1, 1);
    cyc(0, 4'b0011, 1, 0);
    check("t4_next_idx", 32'(grant_idx), 32'h1);
    cyc(0, 4'b0011, 1, 1);

    // 5. No pre-emption; release by dropping the owner's request.
    cyc(0, 4'b0010, 0, 0);
    cyc(0, 4'b1010, 0, 0);
    check("t5_hold_a", 32'(grant), 32'h2);
    cyc(0, 4'b1010, 0, 0);
    check("t5_hold_b", 32'(grant), 32'h2);
    cyc(0, 4'b1000, 0, 0);
    check("t5_drop_release", 32'(V), 32'h0);
    cyc(0, 4'b1000, 0, 0);
    check("t5_next_grant", 32'(grant), 32'h8);
    cyc(0, 4'b1000, 0, 1);

    // Mode is latched at grant time: RR grant (ptr=2, wraps to 0) released
    // while mode=0 still advances ptr to 1.
    cyc(0, 4'b0001, 1, 0);
    check("mode_rr_wrap", 32'(grant_idx), 32'h0);
    cyc(0, 4'b0001, 0, 0);
    cyc(0, 4'b0001, 0, 1);
    cyc(0, 4'b1111, 1, 0);
    check("mode_latched_ptr", 32'(grant_idx), 32'h1);
    cyc(0, 4'b1111, 1, 1);

    // done in IDLE is ignored: a request with done still gets granted.
    cyc(0, 4'b0000, 0, 1);
    cyc(0, 4'b0010, 0, 1);
    check("idle_done_ignored", 32'(grant), 32'h2);
    cyc(0, 4'b0010, 0, 1);

    // 6. Reset while BUSY, then round-robin grant afterwards.
    cyc(0, 4'b0100, 0, 0);
    check("t6_busy_grant", 32'(grant), 32'h4);
    cyc(1, 4'b0100, 0, 0);
    check("t6_rst_grant", 32'(grant), 32'h0);
    check("t6_rst_v", 32'(V), 32'h0);
    cyc(0, 4'b0100, 1, 0);
    check("t6_post_rst_idx", 32'(grant_idx), 32'h2);
    cyc(0, 4'b0100, 1, 1);
    // ptr=3 now; grant 3, then reset mid-BUSY must return ptr to 0.
    cyc(0, 4'b1111, 1, 0);
    check("t6_ptr3_idx", 32'(grant_idx), 32'h3);
    cyc(1, 4'b1111, 1, 0);
    cyc(0, 4'b1111, 1, 0);
    check("t6_ptr_reset_idx", 32'(grant_idx), 32'h0);
    cyc(0, 4'b1111, 1, 1);
    cyc(0, 4'b0000, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
